miriscv_fetch_pc: RTL and testbench
===================================

# miriscv_fetch_pc

Instruction-fetch PC generator and fetch buffer that feeds the static branch predictor and decode. It owns the fetch PC, issues word requests to instruction memory, and passes each returned instruction through the combinational predictor. It redirects the next fetch to the B-type target when the predictor flags taken, and queues fetched instructions in a 2-entry FIFO toward decode. Execute-stage redirects (mispredict, jumps) flush the buffer and discard stale responses.

## Interface
- `XLEN`, 32, data/address width (from `miriscv_pkg`)
- `BOOT_ADDR`, 32'h0000_0000, first fetch address after reset
- `clk_i` in 1 — core clock
- `arstn_i` in 1 — asynchronous active-low reset
- `instr_req_o` out 1 — fetch request; memory accepts unconditionally in the cycle it is high
- `instr_addr_o` out XLEN — fetch address, bits [1:0] always 0
- `instr_rvalid_i` in 1 — response valid, at least 1 cycle after its request
- `instr_rdata_i` in XLEN — response instruction; also wired to the predictor at top level
- `predicted_flag_i` in 1 — predictor output for `instr_rdata_i`, same cycle
- `f_valid_o` out 1 — FIFO head valid toward decode
- `f_instr_o` out XLEN — head instruction
- `f_pc_o` out XLEN — head PC
- `f_pred_taken_o` out 1 — head was predicted taken
- `d_ready_i` in 1 — decode pops the head when `f_valid_o & d_ready_i`
- `redirect_i` in 1 — execute redirect (mispredict/jump)
- `redirect_pc_i` in XLEN — redirect target; bits [1:0] ignored

## Operation
- FSM states:
  - BOOT: the single cycle after reset release; no request. Next state is RUN.
  - RUN: normal fetching.
  - FLUSH: waiting to drop one stale response.
- At most one request is outstanding. `outst` sets on issue and clears on `instr_rvalid_i`.
- Issue condition in RUN, no redirect: (`outst`=0 or `instr_rvalid_i`) and FIFO occupancy after this cycle's push/pop ≤ 1.
- On an accepted response (`instr_rvalid_i`, not discarded, no redirect), push {rdata, fetch PC of that request, pred}. `pred` is `predicted_flag_i` when `MIRISCV_STATIC_BP_EN` is defined, else 0.
- Next fetch PC after a response:
  - pred=1: `resp_pc + sext({i[31], i[7], i[30:25], i[11:8], 1'b0})`
  - otherwise: `resp_pc + 4`
  - All arithmetic is modulo 2^XLEN (0xFFFF_FFFC + 4 wraps to 0).
- `instr_addr_o` equals the PC register. The PC updates on each accepted response; the response-derived next PC is forwarded combinationally, so issuing in the response cycle uses the new address.
- Redirect, which has the highest priority:
  - Flushes the FIFO (pop ignored) and loads PC ← {`redirect_pc_i`[XLEN-1:2], 2'b00}.
  - No request is issued in the redirect cycle.
  - If `outst`=1 and no rvalid that cycle, go to FLUSH. Otherwise stay in RUN.
  - An rvalid coinciding with the redirect is dropped.
- FLUSH:
  - No requests are issued.
  - The next rvalid is dropped and the state returns to RUN.
  - A further redirect in FLUSH only reloads PC.
- An rvalid with `outst`=0 is ignored, and no X-propagation results.
- Reset values:
  - `instr_req_o`=0, `instr_addr_o`=`BOOT_ADDR`
  - `f_valid_o`=0, `f_instr_o`=0, `f_pc_o`=0, `f_pred_taken_o`=0
  - State BOOT, `outst`=0, FIFO empty
- Reset mid-operation clears everything asynchronously, and any in-flight response is ignored.

## Timing
- Requests with 1-cycle memory latency:
  - Reset released at edge 0; first `instr_req_o` is high in cycle 1 at `BOOT_ADDR`.
  - rvalid arrives in cycle 2; `f_valid_o` is high in cycle 3.
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and `d_ready_i`=1.
- Prediction cost: a taken prediction changes the address of the request issued in the response cycle, so there is no bubble.
- Redirect at cycle t:
  - FIFO is empty at t+1.
  - Request to the target at t+1 if nothing is outstanding; otherwise one cycle after the stale rvalid.
- FIFO full (2) with a stall holds `instr_req_o` low. Data is never lost or reordered.
- The `f_*` outputs are registered FIFO head. `predicted_flag_i` → `instr_addr_o` is a combinational path.

## Configuration
- `MIRISCV_STATIC_BP_EN` defined: prediction is used as described above.
- `MIRISCV_STATIC_BP_EN` undefined:
  - `predicted_flag_i` is ignored.
  - Next PC is always `resp_pc + 4`.
  - `f_pred_taken_o` is tied 0.
  - Target adder logic is removed.

## Test plan
- Reset, `BOOT_ADDR`=0x100, 1-cycle memory returning 0x00000013, `d_ready_i`=1 → requests at 0x100, 0x104, 0x108 in consecutive cycles; `f_pc_o` follows the same sequence with `f_pred_taken_o`=0.
- Response at PC 0x200 with 0xFE000EE3 (beq x0,x0,-4), predictor=1 → next request at 0x1FC, and the FIFO entry shows `f_pred_taken_o`=1.
  - With the macro undefined, the next request is at 0x204 and `f_pred_taken_o`=0.
- Hold `d_ready_i`=0 for 10 cycles → exactly 2 entries buffered and `instr_req_o` low. Release → the entries pop in order and fetch resumes with no duplicated or skipped PC.
- `redirect_i`=1 with `redirect_pc_i`=0x403 while a 3-cycle-latency response is outstanding → stale response dropped, next request at 0x400, FIFO empty until the 0x400 data returns.
- Redirect in the same cycle as rvalid and `d_ready_i` → response dropped, FIFO flushed, request at the target the following cycle.
- PC 0xFFFF_FFFC with a not-taken response → next request at 0x0. Assert `arstn_i` mid-burst → all outputs take their reset values immediately.

Source files
------------

// File: rtl/miriscv_fetch_pc.sv
// Fetch PC generator with a 2-entry fetch buffer toward decode.
// Define MIRISCV_STATIC_BP_EN to follow taken predictions from the static branch predictor.
module miriscv_fetch_pc #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] BOOT_ADDR = '0
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    output logic            instr_req_o,
    output logic [XLEN-1:0] instr_addr_o,
    input  logic            instr_rvalid_i,
    input  logic [XLEN-1:0] instr_rdata_i,
    input  logic            predicted_flag_i,
    output logic            f_valid_o,
    output logic [XLEN-1:0] f_instr_o,
    output logic [XLEN-1:0] f_pc_o,
    output logic            f_pred_taken_o,
    input  logic            d_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i
);

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            pred;
    } fent_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic            r_outst;
    fent_t           r_q [2];
    logic [1:0]      r_cnt;

    logic            w_rsp, w_pop, w_issue, w_pred, w_widx;
    logic [1:0]      w_cnt_after;
    logic [XLEN-1:0] w_nxt_pc;
    fent_t           w_new;
    logic            w_unused_rpc;

    assign w_unused_rpc = ^redirect_pc_i[1:0];

    // Only a response to our own outstanding request in RUN is kept.
    assign w_rsp       = (r_state == ST_RUN) & r_outst & instr_rvalid_i & ~redirect_i;
    assign w_pop       = (r_cnt != 2'd0) & d_ready_i & ~redirect_i;
    assign w_cnt_after = r_cnt + {1'b0, w_rsp} - {1'b0, w_pop};
    assign w_issue     = (r_state == ST_RUN) & ~redirect_i & (~r_outst | instr_rvalid_i)
                       & (w_cnt_after <= 2'd1);

`ifdef MIRISCV_STATIC_BP_EN
    logic [XLEN-1:0] w_bimm;
    assign w_pred   = predicted_flag_i;
    assign w_bimm   = {{(XLEN-12){instr_rdata_i[31]}}, instr_rdata_i[7],
                       instr_rdata_i[30:25], instr_rdata_i[11:8], 1'b0};
    assign w_nxt_pc = r_pc + (w_pred ? w_bimm : XLEN'(4));
`else
    logic w_unused_pred;
    assign w_unused_pred = predicted_flag_i;
    assign w_pred        = 1'b0;
    assign w_nxt_pc      = r_pc + XLEN'(4);
`endif

    assign instr_req_o  = w_issue;
    assign instr_addr_o = w_rsp ? w_nxt_pc : r_pc;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (redirect_i && r_outst && !instr_rvalid_i) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (instr_rvalid_i) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state <= ST_BOOT;
            r_pc    <= BOOT_ADDR;
            r_outst <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_i)
                r_pc <= {redirect_pc_i[XLEN-1:2], 2'b00};
            else if (w_rsp)
                r_pc <= w_nxt_pc;
            if (w_issue)
                r_outst <= 1'b1;
            else if (instr_rvalid_i)
                r_outst <= 1'b0;
        end
    end

    // Shift FIFO: entry 0 is always the head, so f_* come straight from flops.
    assign w_new  = '{instr: instr_rdata_i, pc: r_pc, pred: w_pred};
    assign w_widx = w_pop ? r_cnt[1] : r_cnt[0];

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_cnt  <= 2'd0;
            r_q[0] <= '0;
            r_q[1] <= '0;
        end else if (redirect_i) begin
            r_cnt <= 2'd0;
        end else begin
            r_cnt <= w_cnt_after;
            if (w_pop)
                r_q[0] <= r_q[1];
            if (w_rsp)
                r_q[w_widx] <= w_new;
        end
    end

    assign f_valid_o      = (r_cnt != 2'd0);
    assign f_instr_o      = r_q[0].instr;
    assign f_pc_o         = r_q[0].pc;
    assign f_pred_taken_o = r_q[0].pred;

endmodule

// File: tb/tb_miriscv_fetch_pc.sv
// Bench for miriscv_fetch_pc: directed timing scenarios, then random traffic against an event-level model.
module tb_miriscv_fetch_pc;
    localparam logic [31:0] BOOT = 32'h0000_0100;
`ifdef MIRISCV_STATIC_BP_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk_i = 1'b0, arstn_i = 1'b1;
    logic        instr_req_o, instr_rvalid_i = 1'b0, predicted_flag_i = 1'b0;
    logic [31:0] instr_addr_o, instr_rdata_i = '0;
    logic        f_valid_o, f_pred_taken_o, d_ready_i = 1'b1, redirect_i = 1'b0;
    logic [31:0] f_instr_o, f_pc_o, redirect_pc_i = '0;

    miriscv_fetch_pc #(.XLEN(32), .BOOT_ADDR(BOOT)) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .predicted_flag_i(predicted_flag_i),
        .f_valid_o(f_valid_o), .f_instr_o(f_instr_o), .f_pc_o(f_pc_o),
        .f_pred_taken_o(f_pred_taken_o), .d_ready_i(d_ready_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0, n_err = 0, n_pop = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic pred; } ent_t;
    ent_t        q[$];
    bit          m_outst, m_drop;
    logic [31:0] m_exp, m_req_pc;

    bit          pend, rnd_mode, cur_pf;
    logic [31:0] pend_addr;
    int          pend_cnt, lat_fixed, cur_off;

    logic        s_req, s_fv, s_fpred;
    logic [31:0] s_addr, s_fpc, s_fins;

    // Memory content: nops, plus B-type branches with a known offset.
    task automatic gen(input logic [31:0] a, output logic [31:0] ins, output int off, output bit pf);
        int k, m;
        logic [12:0] imm;
        ins = 32'h0000_0013; off = 4; pf = 1'b0;
        if (!rnd_mode) begin
            if (a == 32'h200) begin ins = 32'hFE00_0EE3; off = -4; pf = 1'b1; end
        end else begin
            k = $urandom_range(0, 9);
            if (k >= 6) begin
                m   = $urandom_range(1, 1000);
                off = (k < 8) ? -4 * m : 4 * m;
                imm = off[12:0];
                ins = {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
                pf  = (k < 8);
            end
        end
    endtask

    // Event-level reference: order of fetched PCs and the decode queue.
    task automatic model_step();
        chk("f_valid", s_fv, q.size() > 0);
        if (redirect_i) begin
            chk("req_in_redirect", s_req, 0);
            q.delete();
            if (m_outst) begin
                if (instr_rvalid_i) begin m_outst = 0; m_drop = 0; end
                else m_drop = 1;
            end
            m_exp = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (s_fv && d_ready_i && q.size() > 0) begin
                chk("pop_instr", s_fins, q[0].instr);
                chk("pop_pc", s_fpc, q[0].pc);
                chk("pop_pred", s_fpred, q[0].pred);
                void'(q.pop_front());
                n_pop++;
            end
            if (instr_rvalid_i && m_outst) begin
                m_outst = 0;
                if (m_drop) m_drop = 0;
                else begin
                    q.push_back('{instr: instr_rdata_i, pc: m_req_pc, pred: BP & cur_pf});
                    m_exp = (BP && cur_pf) ? m_req_pc + 32'(cur_off) : m_req_pc + 32'd4;
                end
            end
            if (s_req) begin
                chk("req_busy", m_outst | m_drop, 0);
                chk("req_addr", s_addr, m_exp);
                m_outst  = 1;
                m_req_pc = s_addr;
            end
            chk("fifo_depth", q.size() <= 2, 1);
        end
    endtask

    task automatic cyc();
        logic [31:0] ins;
        int off;
        bit pf;
        @(negedge clk_i);
        s_req = instr_req_o; s_addr = instr_addr_o; s_fv = f_valid_o;
        s_fpc = f_pc_o; s_fins = f_instr_o; s_fpred = f_pred_taken_o;
        model_step();
        if (s_req) begin
            pend = 1; pend_addr = s_addr;
            pend_cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
        end
        @(posedge clk_i); #1;
        redirect_i = 0; instr_rvalid_i = 0; instr_rdata_i = $urandom;
        predicted_flag_i = 1'($urandom_range(0, 1)); cur_pf = 0; cur_off = 4;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend = 0;
                gen(pend_addr, ins, off, pf);
                instr_rvalid_i = 1; instr_rdata_i = ins; predicted_flag_i = pf;
                cur_off = off; cur_pf = pf;
            end
        end else if (rnd_mode && $urandom_range(0, 19) == 0) begin
            instr_rvalid_i = 1;
        end
        if (rnd_mode) begin
            d_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 31) == 0) begin redirect_i = 1; redirect_pc_i = $urandom; end
        end
    endtask

    task automatic wait_req(input string tag, output logic [31:0] a);
        int n = 0;
        do begin cyc(); n++; end while (!s_req && n < 20);
        chk({tag, "_seen"}, s_req, 1);
        a = s_addr;
    endtask

    task automatic do_reset(input bit stray);
        arstn_i = 0; #1;
        chk("rst_req", instr_req_o, 0);
        chk("rst_addr", instr_addr_o, BOOT);
        chk("rst_fv", f_valid_o, 0);
        chk("rst_fins", f_instr_o, 0);
        chk("rst_fpc", f_pc_o, 0);
        chk("rst_fpred", f_pred_taken_o, 0);
        q.delete(); m_outst = 0; m_drop = 0; m_exp = BOOT; pend = 0;
        redirect_i = 0; instr_rvalid_i = 0; d_ready_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        arstn_i = 1;
        if (stray) begin instr_rvalid_i = 1; instr_rdata_i = $urandom; end
    endtask

    initial begin
        logic [31:0] a, p;
        int n;
        lat_fixed = 1; rnd_mode = 0;
        #3;
        do_reset(0);

        // Boot sequence, 1-cycle memory, sustained fetch.
        cyc(); chk("boot_noreq", s_req, 0);
        cyc(); chk("c1_req", s_req, 1); chk("c1_addr", s_addr, 32'h100);
        cyc(); chk("c2_addr", s_addr, 32'h104); chk("c2_fv", s_fv, 0);
        cyc(); chk("c3_addr", s_addr, 32'h108); chk("c3_fv", s_fv, 1);
        chk("c3_fpc", s_fpc, 32'h100); chk("c3_fins", s_fins, 32'h13); chk("c3_fpred", s_fpred, 0);
        cyc(); chk("c4_req", s_req, 1); chk("c4_fpc", s_fpc, 32'h104);

        // Redirect coinciding with rvalid and pop, then a predicted backward branch at 0x200.
        redirect_i = 1; redirect_pc_i = 32'h200;
        cyc(); chk("rd_noreq", s_req, 0);
        cyc(); chk("rd_fv", s_fv, 0); chk("rd_req", s_req, 1); chk("rd_addr", s_addr, 32'h200);
        cyc(); chk("br_req", s_req, 1); chk("br_addr", s_addr, BP ? 32'h1FC : 32'h204);
        cyc(); chk("br_fv", s_fv, 1); chk("br_fpc", s_fpc, 32'h200);
        chk("br_fins", s_fins, 32'hFE00_0EE3); chk("br_fpred", s_fpred, BP);

        // Decode stall fills the buffer, then drains in order.
        redirect_i = 1; redirect_pc_i = 32'h1000;
        repeat (4) cyc();
        d_ready_i = 0;
        repeat (10) cyc();
        chk("st_req", s_req, 0); chk("st_fv", s_fv, 1);
        p = s_fpc;
        d_ready_i = 1;
        cyc(); chk("rl_fpc0", s_fpc, p); chk("rl_req", s_req, 1); chk("rl_addr", s_addr, p + 8);
        cyc(); chk("rl_fv1", s_fv, 1); chk("rl_fpc1", s_fpc, p + 4);
        cyc(); chk("rl_fv2", s_fv, 1); chk("rl_fpc2", s_fpc, p + 8);

        // Redirect while a 3-cycle response is outstanding.
        lat_fixed = 3; n = 0;
        do begin cyc(); n++; end while (!s_req && n < 10);
        chk("fl_pre_req", s_req, 1);
        redirect_i = 1; redirect_pc_i = 32'h403;
        cyc(); chk("fl_rd_noreq", s_req, 0);
        cyc(); chk("fl_noreq_a", s_req, 0); chk("fl_fv_a", s_fv, 0);
        cyc(); chk("fl_noreq_b", s_req, 0);
        cyc(); chk("fl_req", s_req, 1); chk("fl_addr", s_addr, 32'h400); chk("fl_fv_b", s_fv, 0);
        repeat (3) begin cyc(); chk("fl_fv_wait", s_fv, 0); end
        cyc(); chk("fl_fv", s_fv, 1); chk("fl_fpc", s_fpc, 32'h400);

        // Address wrap; low redirect bits are dropped.
        lat_fixed = 1;
        repeat (6) cyc();
        redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFF;
        wait_req("wr_a", a); chk("wr_a", a, 32'hFFFF_FFFC);
        wait_req("wr_b", a); chk("wr_b", a, 32'h0);

        // Reset mid-burst, with a stray response in the boot cycle.
        repeat (3) cyc();
        #2;
        do_reset(1);
        cyc(); chk("rb_noreq", s_req, 0);
        cyc(); chk("rb_req", s_req, 1); chk("rb_addr", s_addr, BOOT);

        // Random traffic against the model.
        rnd_mode = 1; lat_fixed = 0;
        repeat (4000) cyc();
        chk("progress", n_pop > 200, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
